// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TMO  = 2'd2
  } wb_state_e;

  localparam int          TMO_CNT_W   = 16;
  localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout.sv
// Slave-response watchdog: counts unacknowledged strobe cycles and flags when
// the count has reached the programmed threshold.
module wb_timeout
  import wb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [TMO_CNT_W-1:0] i_threshold,
  output logic                 o_expired
);

  logic [TMO_CNT_W-1:0] count_q;
  logic [TMO_CNT_W-1:0] count_d;

  // Clear dominates so an ack in the threshold cycle never counts as a stall.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == i_threshold);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter with cycle locking, round-robin or
// fixed-priority grant, and a slave-response timeout that fakes an ack.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_stb,
  input  logic        i_m0_cyc,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_stb,
  input  logic        i_m1_cyc,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_dat,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_dat,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic        o_owner,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e state_q, state_d;
  logic      owner_q, owner_d;
  logic      last_owner_q, last_owner_d;
  logic      grant;
  logic      own_cyc, own_stb;
  logic      tmo_clear, tmo_enable, tmo_expired;

  assign own_cyc = owner_q ? i_m1_cyc : i_m0_cyc;
  assign own_stb = owner_q ? i_m1_stb : i_m0_stb;

  // On contention round-robin favours whoever did not win last time.
  always_comb begin
    grant = i_m1_cyc;
    if (i_m0_cyc && i_m1_cyc) begin
      grant = (ROUND_ROBIN != 0) ? ~last_owner_q : 1'b0;
    end
  end

  assign tmo_clear  = (state_q != BUSY) || i_wb_ack || !own_stb;
  assign tmo_enable = (state_q == BUSY) && own_stb && !i_wb_ack;

  wb_timeout u_timeout (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (tmo_clear),
    .i_enable    (tmo_enable),
    .i_threshold (TMO_LIMIT),
    .o_expired   (tmo_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc || i_m1_cyc) begin
          state_d      = BUSY;
          owner_d      = grant;
          last_owner_d = grant;
        end
      end
      BUSY: begin
        // A same-cycle ack beats the threshold.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (tmo_expired && own_stb && !i_wb_ack) begin
          state_d = TMO;
        end
      end
      TMO:     state_d = own_cyc ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_cyc = 1'b0;
    o_m0_ack = 1'b0;
    o_m0_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_dat = '0;
    o_err    = 1'b0;
    case (state_q)
      BUSY: begin
        if (owner_q) begin
          o_wb_adr = i_m1_adr;
          o_wb_dat = i_m1_dat;
          o_wb_sel = i_m1_sel;
          o_wb_we  = i_m1_we;
          o_wb_stb = i_m1_stb;
          o_wb_cyc = i_m1_cyc;
          o_m1_ack = i_wb_ack;
          o_m1_dat = i_wb_dat;
        end else begin
          o_wb_adr = i_m0_adr;
          o_wb_dat = i_m0_dat;
          o_wb_sel = i_m0_sel;
          o_wb_we  = i_m0_we;
          o_wb_stb = i_m0_stb;
          o_wb_cyc = i_m0_cyc;
          o_m0_ack = i_wb_ack;
          o_m0_dat = i_wb_dat;
        end
      end
      TMO: begin
        o_err = 1'b1;
        if (owner_q) begin
          o_m1_ack = 1'b1;
          o_m1_dat = WB_ERR_DATA;
        end else begin
          o_m0_ack = 1'b1;
          o_m0_dat = WB_ERR_DATA;
        end
      end
      default: ;
    endcase
  end

  assign o_owner = owner_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus hand-written
// timeout, fixed-priority and reset sequences.
module tb_wb_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_1111;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_dat = '0;

  logic        m0_ack, m1_ack, wb_we, wb_stb, wb_cyc, owner, busy, err;
  logic [31:0] m0_dat, m1_dat, wb_adr, wb_dout;
  logic [3:0]  wb_sel;

  logic        f_m0_ack, f_m1_ack, f_we, f_stb, f_cyc, f_owner, f_busy, f_err;
  logic [31:0] f_m0_dat, f_m1_dat, f_adr, f_dout;
  logic [3:0]  f_sel;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_adr(A0), .i_m0_dat(D0), .i_m0_sel(4'hF), .i_m0_we(1'b0),
    .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
    .i_m1_adr(A1), .i_m1_dat(D1), .i_m1_sel(4'h3), .i_m1_we(1'b1),
    .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
    .o_m0_ack(m0_ack), .o_m0_dat(m0_dat), .o_m1_ack(m1_ack), .o_m1_dat(m1_dat),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dout), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
    .o_wb_stb(wb_stb), .o_wb_cyc(wb_cyc), .i_wb_ack(wb_ack), .i_wb_dat(wb_dat),
    .o_owner(owner), .o_busy(busy), .o_err(err)
  );

  wb_arbiter #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(0)) dut_fp (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_adr(A0), .i_m0_dat(D0), .i_m0_sel(4'hF), .i_m0_we(1'b0),
    .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
    .i_m1_adr(A1), .i_m1_dat(D1), .i_m1_sel(4'h3), .i_m1_we(1'b1),
    .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
    .o_m0_ack(f_m0_ack), .o_m0_dat(f_m0_dat), .o_m1_ack(f_m1_ack), .o_m1_dat(f_m1_dat),
    .o_wb_adr(f_adr), .o_wb_dat(f_dout), .o_wb_sel(f_sel), .o_wb_we(f_we),
    .o_wb_stb(f_stb), .o_wb_cyc(f_cyc), .i_wb_ack(wb_ack), .i_wb_dat(wb_dat),
    .o_owner(f_owner), .o_busy(f_busy), .o_err(f_err)
  );

  typedef struct {
    logic        m0c, m0s, m1c, m1s, ack;
    logic [31:0] dat;
    logic        e_cyc, e_stb;
    logic [31:0] e_adr;
    logic        e_m0a;
    logic [31:0] e_m0d;
    logic        e_m1a;
    logic [31:0] e_m1d;
    logic        e_own, e_busy, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic m0c, logic m0s, logic m1c, logic m1s, logic ack,
                              logic [31:0] dat, logic e_cyc, logic e_stb, logic [31:0] e_adr,
                              logic e_m0a, logic [31:0] e_m0d, logic e_m1a, logic [31:0] e_m1d,
                              logic e_own, logic e_busy, logic e_err);
    vec_t v;
    v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.ack = ack; v.dat = dat;
    v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_adr = e_adr;
    v.e_m0a = e_m0a; v.e_m0d = e_m0d; v.e_m1a = e_m1a; v.e_m1d = e_m1d;
    v.e_own = e_own; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic d,
                       input logic ack, input logic [31:0] dat);
    m0_cyc = a; m0_stb = b; m1_cyc = c; m1_stb = d; wb_ack = ack; wb_dat = dat;
  endtask

  // Advance to the next falling edge, apply inputs, settle before sampling.
  task automatic step(input logic a, input logic b, input logic c, input logic d,
                      input logic ack, input logic [31:0] dat);
    @(negedge i_clk);
    drive(a, b, c, d, ack, dat);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    drive(0, 0, 0, 0, 0, '0);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    // Contention after reset, hand-over, repeat contention, abort, m0 alone read.
    vecs.push_back(mk(1,1,1,1,0,'0,            0,0,'0, 0,'0,0,'0,            0,0,0));
    vecs.push_back(mk(1,1,1,1,0,'0,            1,1,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(1,1,1,1,1,32'hA5,        1,1,A0, 1,32'hA5,0,'0,        0,1,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            0,0,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            0,0,'0, 0,'0,0,'0,            0,0,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            1,1,A1, 0,'0,0,'0,            1,1,0));
    vecs.push_back(mk(0,0,1,1,1,32'h0B0B,      1,1,A1, 0,'0,1,32'h0B0B,      1,1,0));
    vecs.push_back(mk(0,0,0,0,0,'0,            0,0,A1, 0,'0,0,'0,            1,1,0));
    vecs.push_back(mk(1,1,1,1,0,'0,            0,0,'0, 0,'0,0,'0,            1,0,0));
    vecs.push_back(mk(1,1,1,1,0,'0,            1,1,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(1,1,1,1,1,32'h0C0C,      1,1,A0, 1,32'h0C0C,0,'0,      0,1,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            0,0,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            0,0,'0, 0,'0,0,'0,            0,0,0));
    vecs.push_back(mk(0,0,1,1,0,'0,            1,1,A1, 0,'0,0,'0,            1,1,0));
    vecs.push_back(mk(0,0,0,1,0,'0,            0,1,A1, 0,'0,0,'0,            1,1,0));
    vecs.push_back(mk(0,0,0,0,0,'0,            0,0,'0, 0,'0,0,'0,            1,0,0));
    vecs.push_back(mk(1,1,0,0,0,'0,            0,0,'0, 0,'0,0,'0,            1,0,0));
    vecs.push_back(mk(1,1,0,0,0,'0,            1,1,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(1,1,0,0,0,'0,            1,1,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(1,1,0,0,0,'0,            1,1,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(1,1,0,0,1,32'h1234_5678, 1,1,A0, 1,32'h1234_5678,0,'0, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0,'0,            0,0,A0, 0,'0,0,'0,            0,1,0));
    vecs.push_back(mk(0,0,0,0,0,'0,            0,0,'0, 0,'0,0,'0,            0,0,0));

    // Reset values while held in reset.
    #3;
    chk("rst wb_cyc", wb_cyc, 0);
    chk("rst wb_stb", wb_stb, 0);
    chk("rst owner", owner, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst m0_ack", m0_ack, 0);
    chk("rst wb_adr", wb_adr, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s, vecs[i].ack, vecs[i].dat);
      chk($sformatf("v%0d wb_cyc", i), wb_cyc, vecs[i].e_cyc);
      chk($sformatf("v%0d wb_stb", i), wb_stb, vecs[i].e_stb);
      chk($sformatf("v%0d wb_adr", i), wb_adr, vecs[i].e_adr);
      chk($sformatf("v%0d m0_ack", i), m0_ack, vecs[i].e_m0a);
      chk($sformatf("v%0d m0_dat", i), m0_dat, vecs[i].e_m0d);
      chk($sformatf("v%0d m1_ack", i), m1_ack, vecs[i].e_m1a);
      chk($sformatf("v%0d m1_dat", i), m1_dat, vecs[i].e_m1d);
      chk($sformatf("v%0d owner", i), owner, vecs[i].e_own);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d err", i), err, vecs[i].e_err);
    end

    // Timeout: no ack, TMO 8 cycles after the strobe reaches the bus.
    step(1, 1, 0, 0, 0, '0);
    chk("tmo idle busy", busy, 0);
    for (int c = 1; c <= 8; c++) begin
      step(1, 1, 0, 0, 0, '0);
      chk($sformatf("tmo c%0d wb_stb", c), wb_stb, 1);
      chk($sformatf("tmo c%0d err", c), err, 0);
      chk($sformatf("tmo c%0d m0_ack", c), m0_ack, 0);
      if (c == 1) begin
        chk("tmo wb_sel", wb_sel, 4'hF);
        chk("tmo wb_we", wb_we, 0);
        chk("tmo wb_dat", wb_dout, D0);
      end
    end
    step(1, 1, 0, 0, 0, '0);
    chk("tmo pulse wb_stb", wb_stb, 0);
    chk("tmo pulse wb_cyc", wb_cyc, 0);
    chk("tmo pulse m0_ack", m0_ack, 1);
    chk("tmo pulse m0_dat", m0_dat, 32'hDEAD_BEEF);
    chk("tmo pulse err", err, 1);
    chk("tmo pulse m1_ack", m1_ack, 0);
    step(1, 1, 0, 0, 0, '0);
    chk("tmo after err", err, 0);
    chk("tmo after wb_stb", wb_stb, 1);
    chk("tmo after m0_ack", m0_ack, 0);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    chk("tmo end busy", busy, 0);

    // Ack in the threshold cycle wins over the timeout.
    step(1, 1, 0, 0, 0, '0);
    for (int c = 1; c <= 7; c++) step(1, 1, 0, 0, 0, '0);
    step(1, 1, 0, 0, 1, 32'h5555_AAAA);
    chk("thr m0_ack", m0_ack, 1);
    chk("thr m0_dat", m0_dat, 32'h5555_AAAA);
    chk("thr err", err, 0);
    step(0, 0, 0, 0, 0, '0);
    chk("thr next err", err, 0);
    chk("thr next m0_ack", m0_ack, 0);
    chk("thr next busy", busy, 1);
    step(0, 0, 0, 0, 0, '0);
    chk("thr idle busy", busy, 0);

    // Fixed priority: m0 wins four back-to-back cycles against a waiting m1.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 1, 1, 0, '0);
      chk($sformatf("fp r%0d idle busy", r), f_busy, 0);
      step(1, 1, 1, 1, 1, 32'h100 + r);
      chk($sformatf("fp r%0d owner", r), f_owner, 0);
      chk($sformatf("fp r%0d m0_ack", r), f_m0_ack, 1);
      chk($sformatf("fp r%0d m0_dat", r), f_m0_dat, 32'h100 + r);
      chk($sformatf("fp r%0d m1_ack", r), f_m1_ack, 0);
      step(0, 0, 1, 1, 0, '0);
      chk($sformatf("fp r%0d drop owner", r), f_owner, 0);
    end
    step(0, 0, 1, 1, 0, '0);
    chk("fp m1 idle busy", f_busy, 0);
    step(0, 0, 1, 1, 0, '0);
    chk("fp m1 owner", f_owner, 1);
    chk("fp m1 wb_adr", f_adr, A1);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);

    // Asynchronous reset in mid-transfer; contention afterwards goes to m0.
    do_reset();
    step(1, 1, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, '0);
    chk("arst pre wb_stb", wb_stb, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst wb_cyc", wb_cyc, 0);
    chk("arst wb_stb", wb_stb, 0);
    chk("arst busy", busy, 0);
    chk("arst owner", owner, 0);
    chk("arst wb_adr", wb_adr, 0);
    chk("arst fp wb_cyc", f_cyc, 0);
    @(negedge i_clk);
    drive(1, 1, 1, 1, 0, '0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    chk("arst release busy", busy, 0);
    step(1, 1, 1, 1, 0, '0);
    chk("arst grant busy", busy, 1);
    chk("arst grant owner", owner, 0);
    chk("arst grant wb_adr", wb_adr, A0);
    step(0, 0, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
